// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute-stage controller
// and the M-extension multiply/divide unit.
// The master drives the operation and the flush; the slave returns status and result.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srca, srcb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, srca, srcb, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Multiplication is radix-2 shift-add and division is restoring shift-subtract.
// Both share one 2*XLEN accumulator and are followed by a one-cycle sign fix-up.
// Divide-by-zero and signed overflow return their architectural results
// straight from IDLE without iterating.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies form the full product
// combinationally in IDLE and finish in one cycle. Divides are unaffected.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);
  localparam int CNTW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              neg_hi;
  logic              neg_rem;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   result_r;

  logic              accept;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              direct;
  logic [XLEN-1:0]   direct_val;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   fix_val;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  // Decode the incoming request: operand signs, magnitudes and the results that need no iteration.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin
        sign_a = bus.srca[XLEN-1];
        sign_b = bus.srcb[XLEN-1];
      end
      3'b010:  sign_a = bus.srca[XLEN-1];
      default: ;
    endcase
    mag_a    = sign_a ? -bus.srca : bus.srca;
    mag_b    = sign_b ? -bus.srcb : bus.srcb;
    div_zero = bus.funct3[2] && (bus.srcb == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.srca == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcb == '1);
    direct   = div_zero || div_ovf;
    if (div_zero) begin
      direct_val = bus.funct3[1] ? bus.srca : '1;
    end else begin
      direct_val = bus.funct3[1] ? '0 : bus.srca;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{sign_a}}, bus.srca} * {{XLEN{sign_b}}, bus.srcb};
    if (!bus.funct3[2]) begin
      direct     = 1'b1;
      direct_val = (bus.funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One radix-2 step: the low half holds the multiplier or the dividend bits still to be consumed.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc[0] ? {1'b0, opb} : '0);
    div_trial = {acc_hi, acc[XLEN-1]} - {1'b0, opb};
    if (!op[2]) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end else if (!div_trial[XLEN]) begin
      acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {acc[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and output selection. The negated high product half is ~hi plus a carry out of the zero low half.
  always_comb begin
    fix_val = acc_hi;
    case (op)
      3'b000:         fix_val = acc_lo;
      3'b001, 3'b010: fix_val = neg_hi ? (~acc_hi + XLEN'(acc_lo == '0)) : acc_hi;
      3'b011:         fix_val = acc_hi;
      3'b100:         fix_val = neg_hi ? -acc_lo : acc_lo;
      3'b101:         fix_val = acc_lo;
      3'b110:         fix_val = neg_rem ? -acc_hi : acc_hi;
      default:        fix_val = acc_hi;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere and beats start.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = direct ? DONE : CALC;
        CALC:    if (cnt == '0) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.busy = (state == CALC) || (state == FIX);
    bus.done = (state == DONE);
  end

  assign bus.result = result_r;

  // Datapath: latch the request, iterate, and write the result only when an op really completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op       <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_hi   <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      result_r <= '0;
    end else if (accept) begin
      op      <= bus.funct3;
      acc     <= {{XLEN{1'b0}}, mag_a};
      opb     <= mag_b;
      neg_hi  <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      cnt     <= CNTW'(XLEN - 1);
      if (direct) begin
        result_r <= direct_val;
      end
    end else if (!bus.flush && (state == CALC)) begin
      acc <= acc_step;
      cnt <= cnt - 1'b1;
    end else if (!bus.flush && (state == FIX)) begin
      result_r <= fix_val;
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execute unit, parametrised in XLEN.
- Sits beside the single-cycle ALU in the execute stage. The controller stalls the pipeline while busy=1.
- Decodes the M-extension funct3 internally.
- Handles the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

Parameters:
XLEN, 32, operand/result width; legal values are 32 and 64.
CNTW, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only in IDLE.
funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
srca  input  XLEN  rs1 operand.
srcb  input  XLEN  rs2 operand.
flush  input  1  abort the in-flight op (pipeline flush).
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse; result valid in the same cycle.
result  output  XLEN  result; holds its value until the next accepted start.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 & flush=0: latch funct3, srca and srcb.
  - Signed ops (MULH, MULHSU, DIV, REM) convert the relevant operands to magnitudes and record the result sign.
  - Special cases go directly to DONE:
    - Divide by zero (srcb=0, ops 1xx): quotient=all ones, remainder=srca.
    - Signed overflow (DIV/REM, srca=100..0, srcb=all ones): quotient=srca, remainder=0.
  - Otherwise go to CALC with counter=XLEN-1.
- CALC, one radix-2 step per cycle:
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each cycle; at counter=0 go to FIX.
- FIX, one cycle:
  - Apply the sign correction. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - MULH/MULHSU negate the full 2*XLEN product when the sign flag is set.
  - Select the output: MUL=low XLEN bits; MULH/MULHSU/MULHU=high XLEN bits; DIV/DIVU=quotient; REM/REMU=remainder.
  - Go to DONE.
- DONE, one cycle: done=1, result driven, busy=0; next state IDLE.
- busy=1 in CALC and FIX.
- Latency from the accepting edge to the done pulse:
  - Iterative ops: XLEN+2 cycles (34 for XLEN=32).
  - Special cases: 1 cycle.
- start is ignored when state is not IDLE; no queueing.
- start in the DONE cycle is ignored. A back-to-back start must come at the earliest one cycle after done.
- flush=1 in any state:
  - Next state is IDLE, busy=0, done=0.
  - result keeps its previous value; no done pulse is produced for the aborted op.
  - flush has priority over start.
- Asynchronous reset mid-operation discards the operation immediately.
- Arithmetic is modulo 2^XLEN. The MULHSU rule: srca is signed, srcb is unsigned.
- Width constraint: a signed XLEN-bit magnitude fits in XLEN bits unsigned (100..0 maps to itself).

Optional Feature:
- Macro name: MULDIV_FAST_MUL_EN.
- When defined:
  - Multiply ops (0xx) skip CALC and FIX. The full 2*XLEN signed/unsigned product is computed combinationally in IDLE and registered.
  - Flow is IDLE -> DONE, so latency is 1 cycle.
  - Divides are unchanged.
- When undefined: multiplies use the iterative path with XLEN+2 latency. No multiplier array is inferred.

Test Plan:
- MUL, srca=7, srcb=-3 (0xFFFFFFFD) -> after 34 cycles done=1, result=0xFFFFFFEB; busy high for cycles 1..33; with MULDIV_FAST_MUL_EN, done after 1 cycle, same result.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each completes in 34 cycles.
- DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. Each has done on the cycle after acceptance.
- DIVU 100/7 started, then flush at cycle 10 -> busy=0 next cycle, no done pulse, result unchanged. A new start is accepted immediately and completes correctly. A start asserted while busy is ignored.
- Assert reset_n=0 asynchronously mid-CALC -> busy, done and result go to 0 without a clock edge. After release, the unit accepts a start on the first edge.
